// File: rtl/floor_display_scan.sv
// Four-digit multiplexed 7-segment driver for the elevator car: direction glyph,
// blinking door indicator and two-digit floor, scanned from a synchronised led_clk.
module floor_display_scan #(
  parameter logic [7:0] BLINK_FRAMES = 8'd64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       led_clk,
  input  logic [3:0] floor,
  input  logic [1:0] dir,
  input  logic       door_open,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [7:0] BLINK_LAST = BLINK_FRAMES - 8'd1;
  localparam logic [6:0] BLANK      = 7'h7F;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_BAD  = 2'b11
  } dir_t;

  logic       s1, s2, s3;
  logic       scan_tick;
  logic       pending;
  logic [1:0] idx;
  logic [7:0] blink_cnt;
  logic       blink_phase;
  logic [3:0] snap_floor;
  dir_t       snap_dir;
  logic       snap_door;
  logic [3:0] units;
  logic [3:0] digit_an;
  logic [6:0] digit_seg;

  function automatic logic [6:0] dec_glyph(input logic [3:0] d);
    case (d)
      4'd0:    dec_glyph = 7'h40;
      4'd1:    dec_glyph = 7'h79;
      4'd2:    dec_glyph = 7'h24;
      4'd3:    dec_glyph = 7'h30;
      4'd4:    dec_glyph = 7'h19;
      4'd5:    dec_glyph = 7'h12;
      4'd6:    dec_glyph = 7'h02;
      4'd7:    dec_glyph = 7'h78;
      4'd8:    dec_glyph = 7'h00;
      4'd9:    dec_glyph = 7'h10;
      default: dec_glyph = BLANK;
    endcase
  endfunction

  assign scan_tick = s2 & ~s3;
  assign dp        = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      pending <= 1'b0;
    end else begin
      s1      <= led_clk;
      s2      <= s1;
      s3      <= s2;
      pending <= scan_tick;
    end
  end

  // Index, snapshots and blink all move together at the tick so one frame
  // always renders a single consistent set of inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_floor  <= '0;
      snap_dir    <= DIR_IDLE;
      snap_door   <= 1'b0;
    end else if (scan_tick) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) begin
        snap_floor <= floor;
        snap_dir   <= dir_t'(dir);
        snap_door  <= door_open;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    units     = (snap_floor >= 4'd10) ? snap_floor - 4'd10 : snap_floor;
    digit_an  = ~(4'b0001 << idx);
    digit_seg = BLANK;
    case (idx)
      2'd0: digit_seg = dec_glyph(units);
      2'd1: digit_seg = (snap_floor >= 4'd10) ? dec_glyph(4'd1) : BLANK;
      2'd2: digit_seg = (snap_door && blink_phase) ? 7'h21 : BLANK;
      2'd3: begin
        case (snap_dir)
          DIR_UP:   digit_seg = 7'h7E;
          DIR_DOWN: digit_seg = 7'h77;
          DIR_IDLE: digit_seg = 7'h3F;
          DIR_BAD:  digit_seg = BLANK;
          default:  digit_seg = BLANK;
        endcase
      end
      default: digit_seg = BLANK;
    endcase
  end

  // Blank for the tick cycle, then show the already-advanced index next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= '1;
    end else if (scan_tick) begin
      an  <= '1;
      seg <= '1;
    end else if (pending) begin
      an  <= digit_an;
      seg <= digit_seg;
    end
  end

endmodule

// File: tb/tb_floor_display_scan.sv
// Scoreboard bench for floor_display_scan: predicted digits are queued per led_clk
// rise and matched by a monitor when each new digit lights.
module tb_floor_display_scan;

  localparam int BF = 3;
  localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       led_clk = 1'b0;
  logic [3:0] floor = 4'd7;
  logic [1:0] dir = 2'b01;
  logic       door_open = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  floor_display_scan #(.BLINK_FRAMES(8'd3)) dut (
    .clk(clk), .reset(reset), .led_clk(led_clk), .floor(floor), .dir(dir),
    .door_open(door_open), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model: position in the scan and the frame-level snapshot.
  int         m_idx = 0;
  int         m_frames = 0;
  logic [3:0] m_floor = '0;
  logic [1:0] m_dir = '0;
  logic       m_door = 1'b0;

  task automatic model_reset();
    m_idx = 0; m_frames = 0; m_floor = '0; m_dir = '0; m_door = 1'b0;
    sb.delete();
  endtask

  task automatic model_step();
    exp_t e;
    int   ph;
    m_idx = (m_idx + 1) % 4;
    if (m_idx == 0) begin
      m_floor = floor; m_dir = dir; m_door = door_open;
      m_frames++;
    end
    ph = (m_frames / BF) % 2;
    e.an = 4'hF;
    e.an[m_idx] = 1'b0;
    case (m_idx)
      0: e.seg = GLYPH[int'(m_floor) % 10];
      1: e.seg = (m_floor >= 10) ? GLYPH[1] : 7'h7F;
      2: e.seg = (m_door && ph == 1) ? 7'h21 : 7'h7F;
      default: e.seg = (m_dir == 2'b00) ? 7'h3F : (m_dir == 2'b01) ? 7'h7E :
                       (m_dir == 2'b10) ? 7'h77 : 7'h7F;
    endcase
    e.cyc = cyc + 4;
    sb.push_back(e);
  endtask

  // Rise led_clk, hold high, drop it; caller may change inputs after return.
  task automatic rise_hi(input int hi);
    @(negedge clk);
    led_clk = 1'b1;
    model_step();
    repeat (hi) @(negedge clk);
    led_clk = 1'b0;
  endtask

  task automatic wait_lo(input int lo);
    repeat (lo) @(negedge clk);
  endtask

  task automatic check_blank(input string name);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL %s: an=%b seg=%h dp=%b, want an=1111 seg=7f dp=1", name, an, seg, dp);
    end
  endtask

  // Monitor: a digit is presented when an leaves the all-blank state.
  initial begin : monitor
    logic [3:0] prev_an;
    exp_t e;
    prev_an = 4'hF;
    forever begin
      @(negedge clk);
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot: an=%b, want at most one low bit", an);
      end
      if (!reset && an != 4'hF && prev_an == 4'hF) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_digit: an=%b seg=%h cyc=%0d, want blank", an, seg, cyc);
        end else begin
          e = sb.pop_front();
          if (an !== e.an || seg !== e.seg) begin
            errors++;
            $display("FAIL digit: an=%b seg=%h, want an=%b seg=%h", an, seg, e.an, e.seg);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL latency: appeared cyc=%0d, want cyc=%0d", cyc, e.cyc);
          end
        end
      end
      prev_an = an;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, sb=%0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin : stim
    int hi, lo;
    // Reset state, then idle with led_clk low: display must stay blank.
    repeat (3) @(negedge clk);
    check_blank("reset_state");
    reset = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    check_blank("before_first_tick");

    // Directed: floor 7 up, two frames (first tick after reset lights an[1]).
    for (int i = 0; i < 8; i++) begin rise_hi(9); wait_lo(10); end
    // Floor 12 going down.
    floor = 4'd12; dir = 2'b10;
    for (int i = 0; i < 8; i++) begin rise_hi(9); wait_lo(10); end
    // Door open with floor 3, then change to 9 mid-frame at index 1.
    floor = 4'd3; dir = 2'b00; door_open = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rise_hi(8);
      if (m_idx == 1 && i > 3) floor = 4'd9;
      wait_lo(8);
    end
    for (int i = 0; i < 32; i++) begin rise_hi(7); wait_lo(7); end

    // Randomised scan timing and inputs, changed only while led_clk is low.
    for (int i = 0; i < 300; i++) begin
      hi = int'($urandom_range(6, 12));
      lo = int'($urandom_range(6, 12));
      rise_hi(hi);
      if ($urandom_range(0, 2) == 0) begin
        floor = 4'($urandom_range(0, 15));
        dir = 2'($urandom_range(0, 3));
        door_open = 1'($urandom_range(0, 1));
      end
      wait_lo(lo);
    end

    // Stuck led_clk: nothing new may appear.
    repeat (60) @(negedge clk);

    // Asynchronous reset while digit index 2 is lit.
    for (int i = 0; i < 8 && m_idx != 2; i++) begin rise_hi(8); wait_lo(8); end
    checks++;
    if (an !== 4'b1011) begin
      errors++;
      $display("FAIL pre_reset_digit: an=%b, want 1011", an);
    end
    #2 reset = 1'b1;
    #1 check_blank("async_reset");
    repeat (3) @(negedge clk);
    check_blank("held_reset");
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin rise_hi(8); wait_lo(8); end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d digits never appeared, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
